// File: rtl/job_match_arbiter_pkg.sv
// Shared widths, defaults and request payload type for the job_pe to match-unit arbiter.
package job_match_arbiter_pkg;

  localparam int ADDR_WIDTH            = 16;
  localparam int LAZY_MATCH_LEN        = 4;
  localparam int MATCH_LEN_WIDTH       = 8;
  localparam int MATCH_ARB_NUM_PE      = 4;
  localparam int MATCH_ARB_OUTSTANDING = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [ADDR_WIDTH-1:0]     history_addr;
    logic [LAZY_MATCH_LEN-1:0] tag;
  } match_req_t;

endpackage

// File: rtl/job_match_arbiter_if.sv
// PE-side and match-unit-side handshake bundle; master = arbiter, slave = surrounding logic.
interface job_match_arbiter_if #(
  parameter int NUM_PE          = job_match_arbiter_pkg::MATCH_ARB_NUM_PE,
  parameter int MAX_OUTSTANDING = job_match_arbiter_pkg::MATCH_ARB_OUTSTANDING
);
  import job_match_arbiter_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_PE-1:0]                pe_req_valid;
  logic [NUM_PE*ADDR_WIDTH-1:0]     pe_req_head_addr;
  logic [NUM_PE*ADDR_WIDTH-1:0]     pe_req_history_addr;
  logic [NUM_PE*LAZY_MATCH_LEN-1:0] pe_req_tag;
  logic [NUM_PE-1:0]                pe_req_ready;

  logic                             mu_req_valid;
  logic [ADDR_WIDTH-1:0]            mu_req_head_addr;
  logic [ADDR_WIDTH-1:0]            mu_req_history_addr;
  logic [LAZY_MATCH_LEN-1:0]        mu_req_tag;
  logic                             mu_req_ready;

  logic                             mu_resp_valid;
  logic [MATCH_LEN_WIDTH-1:0]       mu_resp_len;
  logic [LAZY_MATCH_LEN-1:0]        mu_resp_tag;
  logic                             mu_resp_ready;

  logic [NUM_PE-1:0]                pe_resp_valid;
  logic [MATCH_LEN_WIDTH-1:0]       pe_resp_len;
  logic [LAZY_MATCH_LEN-1:0]        pe_resp_tag;
  logic [NUM_PE-1:0]                pe_resp_ready;

  logic [CNT_W-1:0]                 outstanding;

  modport master (
    input  pe_req_valid, pe_req_head_addr, pe_req_history_addr, pe_req_tag,
    output pe_req_ready,
    output mu_req_valid, mu_req_head_addr, mu_req_history_addr, mu_req_tag,
    input  mu_req_ready,
    input  mu_resp_valid, mu_resp_len, mu_resp_tag,
    output mu_resp_ready,
    output pe_resp_valid, pe_resp_len, pe_resp_tag,
    input  pe_resp_ready,
    output outstanding
  );

  modport slave (
    output pe_req_valid, pe_req_head_addr, pe_req_history_addr, pe_req_tag,
    input  pe_req_ready,
    input  mu_req_valid, mu_req_head_addr, mu_req_history_addr, mu_req_tag,
    output mu_req_ready,
    output mu_resp_valid, mu_resp_len, mu_resp_tag,
    input  mu_resp_ready,
    input  pe_resp_valid, pe_resp_len, pe_resp_tag,
    output pe_resp_ready,
    input  outstanding
  );

endinterface

// File: rtl/job_match_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int W     = 4,
  localparam int PTR_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [W-1:0]     grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < W; k++) begin
      idx = PTR_W'((int'(ptr) + k) % W);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_match_arbiter.sv
// Shares one match unit among NUM_PE job_pe requesters; in-order responses are steered
// back to their owner through a FIFO of granted PE indices.
module job_match_arbiter
  import job_match_arbiter_pkg::*;
#(
  parameter int NUM_PE          = MATCH_ARB_NUM_PE,
  parameter int MAX_OUTSTANDING = MATCH_ARB_OUTSTANDING
) (
  input logic                 clk,
  input logic                 rst_n,
  job_match_arbiter_if.master bus
);

  localparam int PE_ID_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int FIFO_AW = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W   = FIFO_AW + 1;

  logic [NUM_PE-1:0]  grant;
  logic [PE_ID_W-1:0] rr_ptr;
  logic [PE_ID_W-1:0] winner;
  match_req_t         winner_req;
  match_req_t         slot;
  logic               slot_valid;
  logic               slot_free;
  logic               grant_en;
  logic               pop;

  logic [PE_ID_W-1:0] id_fifo [MAX_OUTSTANDING];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [PE_ID_W-1:0] head_id;

  rr_arbiter #(.W(NUM_PE)) u_rr (
    .req   (bus.pe_req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    winner     = '0;
    winner_req = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant[i]) begin
        winner                  = PE_ID_W'(i);
        winner_req.head_addr    = bus.pe_req_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        winner_req.history_addr = bus.pe_req_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        winner_req.tag          = bus.pe_req_tag[i*LAZY_MATCH_LEN +: LAZY_MATCH_LEN];
      end
    end
  end

  // A full FIFO blocks grants even when a response pops in the same cycle.
  assign slot_free  = !slot_valid || bus.mu_req_ready;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign grant_en   = slot_free && !fifo_full && (|bus.pe_req_valid);

  assign bus.pe_req_ready        = grant_en ? grant : '0;
  assign bus.mu_req_valid        = slot_valid;
  assign bus.mu_req_head_addr    = slot.head_addr;
  assign bus.mu_req_history_addr = slot.history_addr;
  assign bus.mu_req_tag          = slot.tag;

  assign head_id           = id_fifo[rd_ptr];
  assign bus.pe_resp_valid = (bus.mu_resp_valid && !fifo_empty) ? (NUM_PE'(1) << head_id) : '0;
  assign bus.mu_resp_ready = !fifo_empty && bus.pe_resp_ready[head_id];
  assign bus.pe_resp_len   = bus.mu_resp_len;
  assign bus.pe_resp_tag   = bus.mu_resp_tag;
  assign bus.outstanding   = count;
  assign pop               = bus.mu_resp_valid && bus.mu_resp_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot       <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (grant_en) begin
        slot_valid <= 1'b1;
        slot       <= winner_req;
        rr_ptr     <= (winner == PE_ID_W'(NUM_PE - 1)) ? '0 : winner + PE_ID_W'(1);
      end else if (bus.mu_req_ready) begin
        slot_valid <= 1'b0;
      end
      if (grant_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)      rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + CNT_W'(grant_en) - CNT_W'(pop);
    end
  end

  // NOTE: ID storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (grant_en) id_fifo[wr_ptr] <= winner;
  end

endmodule

// File: doc/job_match_arbiter.md
# job_match_arbiter

Shares one match-length engine among `NUM_PE` job_pe instances. Each PE issues at most one outstanding match request per lazy window; the arbiter grants requesters round-robin, forwards the winner through a registered request stage, and records the winner's PE index in an in-order ID FIFO. In-order responses from the engine are steered back to the owning PE. It sits between the job_pe array and the shared match unit inside the match engine.

## Interface
- `NUM_PE`, 4: number of job_pe requesters; must be ≥2.
- `PE_ID_W`, `$clog2(NUM_PE)`: width of PE index.
- `MAX_OUTSTANDING`, 8: ID FIFO depth (power of 2); limits in-flight requests at the match unit.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pe_req_valid`  in  NUM_PE  per-PE request valid.
- `pe_req_head_addr`  in  NUM_PE*`ADDR_WIDTH`  per-PE head address, packed, PE0 at LSB.
- `pe_req_history_addr`  in  NUM_PE*`ADDR_WIDTH`  per-PE history address.
- `pe_req_tag`  in  NUM_PE*`LAZY_MATCH_LEN`  per-PE one-hot lazy slot tag.
- `pe_req_ready`  out  NUM_PE  per-PE grant/accept.
- `mu_req_valid`  out  1  request to match unit.
- `mu_req_head_addr` / `mu_req_history_addr`  out  `ADDR_WIDTH` each  forwarded addresses.
- `mu_req_tag`  out  `LAZY_MATCH_LEN`  forwarded tag.
- `mu_req_ready`  in  1  match unit accepts request.
- `mu_resp_valid`  in  1  match unit response valid.
- `mu_resp_len`  in  `MATCH_LEN_WIDTH`  extension length.
- `mu_resp_tag`  in  `LAZY_MATCH_LEN`  echoed tag.
- `mu_resp_ready`  out  1  response accepted.
- `pe_resp_valid`  out  NUM_PE  per-PE response valid, at most one bit set.
- `pe_resp_len`  out  `MATCH_LEN_WIDTH`  broadcast length.
- `pe_resp_tag`  out  `LAZY_MATCH_LEN`  broadcast tag.
- `pe_resp_ready`  in  NUM_PE  per-PE response ready.
- `outstanding`  out  `$clog2(MAX_OUTSTANDING)+1`  FIFO occupancy.

## Operation
- Request stage: one output register (`mu_req_*`). Slot "free" when empty or `mu_req_valid && mu_req_ready` this cycle.
- Grant condition: slot free AND FIFO occupancy < MAX_OUTSTANDING (same-cycle response pop does not count; full blocks grant) AND any `pe_req_valid`.
- Arbitration: round-robin starting at `rr_ptr`; winner = first valid PE at index ≥ rr_ptr, wrapping. `pe_req_ready` one-hot to winner, combinational, zero for all others. On grant: load slot, push winner ID, `rr_ptr <= winner+1` mod NUM_PE. No grant → rr_ptr unchanged.
- Response routing: head ID `h` of FIFO; `pe_resp_valid[h] = mu_resp_valid && !empty`; `mu_resp_ready = !empty && pe_resp_ready[h]`; pop on `mu_resp_valid && mu_resp_ready`. Len/tag pass through unchanged.
- FIFO empty with `mu_resp_valid` high: `mu_resp_ready`=0, no `pe_resp_valid`; orphan response stalls (protocol violation, assertion in bench).
- Simultaneous push and pop: occupancy unchanged, both pointers advance; pointers wrap modulo MAX_OUTSTANDING.
- Reset (any time, incl. mid-flight): slot empty, FIFO empty, rr_ptr=0; in-flight IDs discarded; the match unit and PEs are reset together.

## Timing
- Reset values: `mu_req_valid`=0, `mu_req_*` payload=0, `outstanding`=0, `pe_resp_valid`=0, `mu_resp_ready`=0, `pe_req_ready`=0.
- Request latency: grant in cycle N → `mu_req_valid` in N+1. Back-to-back grants every cycle when `mu_req_ready` held high.
- Response latency: 0 cycles (combinational mu_resp → pe_resp).
- `mu_req_valid` once high holds payload stable until accepted.
- A request's own response can arrive no earlier than the cycle after `mu_req` acceptance; ID is already in FIFO.

## Structure
- Add `MATCH_ARB_NUM_PE` and `MATCH_ARB_OUTSTANDING` defaults to parameters.vh; reuse `VEC_SLICE` from util.vh.
- Sub-module `rr_arbiter` (params W; in req, ptr; out one-hot grant); ID FIFO inline as a small register array.

## Test plan
- Single PE1 request head=100,hist=40,tag=0001, mu ready → mu_req at N+1 with same fields; resp len=7 → `pe_resp_valid`=0010, len=7.
- All 4 PEs valid continuously, mu ready → grants PE0,1,2,3,0 in consecutive cycles; responses routed in same order.
- mu_req_ready=0 for 10 cycles, PE2 valid → payload stable, no further grant; release → accepted, next grant next cycle.
- Issue 8 requests with no responses → outstanding=8, `pe_req_ready`=0; one response + pending request same cycle → no grant, grant next cycle, outstanding back to 8.
- Head PE3 `pe_resp_ready`=0 with mu_resp_valid → mu_resp_ready=0, held; assert ready → popped, outstanding decrements.
- Assert rst_n low with 3 outstanding and mu_req_valid=1 → immediately mu_req_valid=0, outstanding=0; next grant starts at PE0.
